halt_dump_unit: RTL and testbench

//  Sits downstream of the MIPS core as the run-end stage. Watches the core PC;

---
 rtl/halt_dump_unit_if.sv | 22 ++
 rtl/halt_dump_unit.sv | 126 ++++++++++++
 tb/tb_halt_dump_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/halt_dump_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : halt_dump_unit_if
//  Description : Valid/ready word stream carrying dumped data-memory words.
//                master drives valid/data/index and samples ready;
//                slave consumes.
//  Ports       : valid  - data/index are presented
//                ready  - consumer accepts the current word
//                data   - dumped 32-bit word
//                index  - 0-based position of the word within the dump
//  Revision    : 1.0 - initial release
// ============================================================================
interface halt_dump_unit_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic [15:0] index;

    modport master (output valid, output data, output index, input ready);
    modport slave  (input valid, input data, input index, output ready);
endinterface
`default_nettype wire

// File: rtl/halt_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : halt_dump_unit
//  Description : Run-end observer for the core. Counts run cycles while the
//                core executes; when pc reaches END_PC it stalls the core and
//                streams DUMP_COUNT data-memory words out over a valid/ready
//                port. A watchdog stops runaway programs after MAX_CYCLES.
//  Ports       : clk, reset (sync, active low)
//                pc            - current core PC
//                cpu_stall     - freeze core state
//                dmem_rd_en/addr/data - second data-memory read port
//                dump          - valid/ready stream of dumped words
//                done          - dump complete (sticky)
//                timeout       - watchdog expired (sticky)
//                cycle_count   - run cycles elapsed, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module halt_dump_unit #(
    parameter logic [31:0] END_PC     = 32'h54,
    parameter int          DUMP_BASE  = 15,
    parameter int          DUMP_COUNT = 1,
    parameter int          ADDR_W     = 8,
    parameter int          MAX_CYCLES = 4096
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [31:0]       pc,
    output logic                   cpu_stall,
    output logic                   dmem_rd_en,
    output logic [ADDR_W-1:0]      dmem_rd_addr,
    input  wire logic [31:0]       dmem_rd_data,
    halt_dump_unit_if.master       dump,
    output logic                   done,
    output logic                   timeout,
    output logic [31:0]            cycle_count
);

    localparam logic [31:0] TMO_AT   = 32'(MAX_CYCLES - 1);
    localparam logic [15:0] LAST_IDX = 16'((DUMP_COUNT == 0) ? 0 : DUMP_COUNT - 1);

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4,
        S_TMO  = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_idx;

    // Read strobe and address decode straight from state so the memory sees
    // the request in the first stalled cycle; address wraps at ADDR_W bits.
    always_comb begin
        dmem_rd_en   = 1'b0;
        dmem_rd_addr = '0;
        if (r_state == S_READ) begin
            dmem_rd_en   = 1'b1;
            dmem_rd_addr = ADDR_W'(DUMP_BASE) + ADDR_W'(r_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_idx       <= '0;
            cycle_count <= '0;
            cpu_stall   <= 1'b0;
            dump.valid  <= 1'b0;
            dump.data   <= '0;
            dump.index  <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                    // END_PC has priority over the watchdog in the same cycle.
                    if (pc == END_PC) begin
                        cpu_stall <= 1'b1;
                        if (DUMP_COUNT == 0) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end else if (cycle_count == TMO_AT) begin
                        cpu_stall <= 1'b1;
                        timeout   <= 1'b1;
                        r_state   <= S_TMO;
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data returns one cycle after the strobe.
                    dump.data  <= dmem_rd_data;
                    dump.index <= r_idx;
                    dump.valid <= 1'b1;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    if (dump.ready) begin
                        dump.valid <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 16'd1;
                            r_state <= S_READ;
                        end
                    end
                end
                default: begin
                    // DONE and TMO are terminal until reset.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_halt_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_halt_dump_unit
//  Description : Scoreboard bench for halt_dump_unit. Four instances with
//                different parameter sets are exercised one after another;
//                expected reads and dumped words are queued as stimulus is
//                issued and a monitor pops/compares them as the DUTs emit.
//                Instances: 0 default, 1 base 254 / count 4,
//                2 watchdog 16 cycles, 3 count 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_halt_dump_unit;

    localparam int NI = 4;
    localparam int BASE_T  [NI] = '{15, 254, 15, 15};
    localparam int COUNT_T [NI] = '{1, 4, 1, 0};
    localparam int MAXC_T  [NI] = '{4096, 4096, 16, 4096};

    logic        clk;
    logic        reset_n    [NI];
    logic [31:0] pc         [NI];
    logic        dump_ready [NI];
    logic        stall      [NI];
    logic        rd_en      [NI];
    logic [7:0]  rd_addr    [NI];
    logic        dump_valid [NI];
    logic [31:0] dump_data  [NI];
    logic [15:0] dump_index [NI];
    logic        done       [NI];
    logic        timeout    [NI];
    logic [31:0] cyc        [NI];

    int checks   = 0;
    int failures = 0;

    // {instance, address}
    logic [15:0] addr_q [$];
    // {instance, 8'h0, index, data}
    logic [63:0] word_q [$];
    logic [15:0] mon_a;
    logic [63:0] mon_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        halt_dump_unit_if bus ();
        logic [31:0] mem_q;

        assign bus.ready     = dump_ready[g];
        assign dump_valid[g] = bus.valid;
        assign dump_data[g]  = bus.data;
        assign dump_index[g] = bus.index;

        // Memory content: word at address a is 0xA5A5A5_aa.
        always_ff @(posedge clk) begin
            if (rd_en[g]) mem_q <= {24'hA5A5A5, rd_addr[g]};
        end

        halt_dump_unit #(
            .END_PC     (32'h54),
            .DUMP_BASE  (BASE_T[g]),
            .DUMP_COUNT (COUNT_T[g]),
            .ADDR_W     (8),
            .MAX_CYCLES (MAXC_T[g])
        ) u_dut (
            .clk          (clk),
            .reset        (reset_n[g]),
            .pc           (pc[g]),
            .cpu_stall    (stall[g]),
            .dmem_rd_en   (rd_en[g]),
            .dmem_rd_addr (rd_addr[g]),
            .dmem_rd_data (mem_q),
            .dump         (bus),
            .done         (done[g]),
            .timeout      (timeout[g]),
            .cycle_count  (cyc[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_word(input int i, input int idx, input logic [7:0] a);
        addr_q.push_back({8'(i), a});
        word_q.push_back({8'(i), 8'h0, 16'(idx), 24'hA5A5A5, a});
    endtask

    task automatic wait_valid(input int i, input int budget, input string name);
        int n = 0;
        while (!dump_valid[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(dump_valid[i]), 64'd1);
    endtask

    task automatic wait_done(input int i, input int budget, output int n);
        n = 0;
        while (!done[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: runs after negedge stimulus has settled, well before posedge.
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < NI; i++) begin
            if (rd_en[i]) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read inst=%0d actual addr=%0d required none", i, rd_addr[i]);
                end else begin
                    mon_a = addr_q.pop_front();
                    chk("rd_addr", 64'({8'(i), rd_addr[i]}), 64'(mon_a));
                end
            end
            if (dump_valid[i] && dump_ready[i]) begin
                if (word_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word inst=%0d actual idx=%0d data=%h required none",
                             i, dump_index[i], dump_data[i]);
                end else begin
                    mon_w = word_q.pop_front();
                    chk("dump_word", {8'(i), 8'h0, dump_index[i], dump_data[i]}, mon_w);
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < NI; i++) begin
            reset_n[i]    = 1'b0;
            pc[i]         = 32'h0;
            dump_ready[i] = 1'b0;
        end

        // ---- Test 1: default instance, run to 0x54, one word from dmem[15]
        repeat (3) @(negedge clk);
        chk("rst_stall",   64'(stall[0]),      64'd0);
        chk("rst_valid",   64'(dump_valid[0]), 64'd0);
        chk("rst_done",    64'(done[0]),       64'd0);
        chk("rst_timeout", 64'(timeout[0]),    64'd0);
        chk("rst_cycles",  64'(cyc[0]),        64'd0);
        dump_ready[0] = 1'b1;
        push_word(0, 0, 8'd15);
        reset_n[0] = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            pc[0] = 32'(k * 4);
            @(negedge clk);
            chk("t1_stall", 64'(stall[0]), (k == 21) ? 64'd1 : 64'd0);
        end
        chk("t1_rd_en_n1", 64'(rd_en[0]), 64'd1);
        chk("t1_cycles",   64'(cyc[0]),   64'd22);
        pc[0] = 32'h0;
        @(negedge clk);
        chk("t1_valid_n2", 64'(dump_valid[0]), 64'd0);
        @(negedge clk);
        chk("t1_valid_n3", 64'(dump_valid[0]), 64'd1);
        chk("t1_data",     64'(dump_data[0]),  64'hA5A5A50F);
        @(negedge clk);
        chk("t1_done",     64'(done[0]),       64'd1);
        chk("t1_valid_off",64'(dump_valid[0]), 64'd0);
        repeat (5) @(negedge clk);
        chk("t1_done_sticky", 64'(done[0]), 64'd1);
        chk("t1_cyc_frozen",  64'(cyc[0]),  64'd22);

        // ---- Test 2/3: wrapping addresses, back-pressure, exact single pop
        for (int j = 0; j < 4; j++) push_word(1, j, 8'(254 + j));
        reset_n[1] = 1'b1;
        pc[1]      = 32'h54;
        @(negedge clk);
        chk("t2_stall", 64'(stall[1]), 64'd1);
        wait_valid(1, 10, "t3_first_valid");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", 64'(dump_valid[1]), 64'd1);
            chk("t3_hold_index", 64'(dump_index[1]), 64'd0);
            chk("t3_hold_data",  64'(dump_data[1]),  64'hA5A5A5FE);
        end
        dump_ready[1] = 1'b1;
        @(negedge clk);
        dump_ready[1] = 1'b0;
        chk("t3_valid_drop", 64'(dump_valid[1]), 64'd0);
        chk("t3_next_read",  64'(rd_en[1]),      64'd1);
        dump_ready[1] = 1'b1;
        wait_done(1, 30, n);
        chk("t2_done",          64'(done[1]), 64'd1);
        chk("t2_cycles_to_done",64'(n),       64'd9);

        // ---- Test 6: reset during OUT, then a fresh run from index 0
        reset_n[1] = 1'b0;
        dump_ready[1] = 1'b0;
        @(negedge clk);
        reset_n[1] = 1'b1;
        push_word(1, 0, 8'd254);
        addr_q.push_back({8'd1, 8'd255});
        wait_valid(1, 10, "t6_valid0");
        dump_ready[1] = 1'b1;
        @(negedge clk);
        dump_ready[1] = 1'b0;
        wait_valid(1, 10, "t6_valid1");
        chk("t6_index1", 64'(dump_index[1]), 64'd1);
        reset_n[1] = 1'b0;
        @(negedge clk);
        chk("t6_stall",   64'(stall[1]),      64'd0);
        chk("t6_rd_en",   64'(rd_en[1]),      64'd0);
        chk("t6_rd_addr", 64'(rd_addr[1]),    64'd0);
        chk("t6_valid",   64'(dump_valid[1]), 64'd0);
        chk("t6_data",    64'(dump_data[1]),  64'd0);
        chk("t6_index",   64'(dump_index[1]), 64'd0);
        chk("t6_done",    64'(done[1]),       64'd0);
        chk("t6_timeout", 64'(timeout[1]),    64'd0);
        chk("t6_cycles",  64'(cyc[1]),        64'd0);
        for (int j = 0; j < 4; j++) push_word(1, j, 8'(254 + j));
        reset_n[1]    = 1'b1;
        dump_ready[1] = 1'b1;
        @(negedge clk);
        chk("t6_cycles_run", 64'(cyc[1]), 64'd1);
        wait_done(1, 30, n);
        chk("t6_done_fresh", 64'(done[1]), 64'd1);

        // ---- Test 4: watchdog after 16 run cycles
        reset_n[2] = 1'b1;
        dump_ready[2] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) begin
                chk("t4_tmo_early",   64'(timeout[2]), 64'd0);
                chk("t4_cycles_15",   64'(cyc[2]),     64'd15);
                chk("t4_stall_early", 64'(stall[2]),   64'd0);
            end
        end
        chk("t4_timeout", 64'(timeout[2]),    64'd1);
        chk("t4_stall",   64'(stall[2]),      64'd1);
        chk("t4_cycles",  64'(cyc[2]),        64'd16);
        chk("t4_valid",   64'(dump_valid[2]), 64'd0);
        pc[2] = 32'h54;
        repeat (4) @(negedge clk);
        chk("t4_no_dump",   64'(done[2]), 64'd0);
        chk("t4_cyc_frozen",64'(cyc[2]),  64'd16);

        // Variant: END_PC on exactly the 16th cycle beats the watchdog
        reset_n[2] = 1'b0;
        pc[2] = 32'h0;
        @(negedge clk);
        reset_n[2] = 1'b1;
        push_word(2, 0, 8'd15);
        for (int k = 1; k <= 16; k++) begin
            pc[2] = (k == 16) ? 32'h54 : 32'h0;
            @(negedge clk);
        end
        chk("t4v_timeout", 64'(timeout[2]), 64'd0);
        chk("t4v_stall",   64'(stall[2]),   64'd1);
        chk("t4v_cycles",  64'(cyc[2]),     64'd16);
        chk("t4v_rd_en",   64'(rd_en[2]),   64'd1);
        wait_done(2, 10, n);
        chk("t4v_done",    64'(done[2]),    64'd1);
        chk("t4v_tmo_end", 64'(timeout[2]), 64'd0);

        // ---- Test 5: zero-length dump
        reset_n[3] = 1'b1;
        @(negedge clk);
        chk("t5_done_early", 64'(done[3]), 64'd0);
        pc[3] = 32'h54;
        @(negedge clk);
        chk("t5_done",  64'(done[3]),  64'd1);
        chk("t5_stall", 64'(stall[3]), 64'd1);
        chk("t5_rd_en", 64'(rd_en[3]), 64'd0);
        repeat (5) @(negedge clk);
        chk("t5_done_sticky", 64'(done[3]), 64'd1);

        @(negedge clk);
        chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
        chk("word_q_empty", 64'(word_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
